// File: rtl/ri_run_controller.sv
// ============================================================================
//  Module   : ri_run_controller
//  Brief    : Run-control sequencer for the R/I-type datapath: loads imem,
//             resets the core and gates core_en for run / single-step.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ri_run_controller #(
    parameter int                 ADDR_W     = 5,
    parameter int                 DATA_W     = 32,
    parameter int                 CNT_W      = 16,
    parameter int                 RST_CYCLES = 2,
    parameter logic [DATA_W-1:0]  HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_data,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_waddr,
    output logic [DATA_W-1:0]     imem_wdata,
    input  logic [ADDR_W-1:0]     core_pc,
    input  logic [DATA_W-1:0]     core_instr,
    output logic                  core_en,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  halted,
    output logic [1:0]            halt_cause,
    output logic [CNT_W-1:0]      retired_cnt
);

    localparam int              c_rcw      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_rcw-1:0] c_rst_init = c_rcw'(RST_CYCLES - 1);

    localparam logic [2:0] c_op_write = 3'd1;
    localparam logic [2:0] c_op_limit = 3'd2;
    localparam logic [2:0] c_op_bkpt  = 3'd3;
    localparam logic [2:0] c_op_crst  = 3'd4;
    localparam logic [2:0] c_op_run   = 3'd5;
    localparam logic [2:0] c_op_step  = 3'd6;
    localparam logic [2:0] c_op_stop  = 3'd7;

    typedef enum logic [1:0] {
        S_CRST = 2'd0,
        S_IDLE = 2'd1,
        S_RUN  = 2'd2,
        S_STEP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_rcw-1:0]    r_rst_cnt;
    logic [CNT_W-1:0]    r_limit;
    logic [CNT_W-1:0]    r_run_cnt;
    logic [CNT_W-1:0]    r_retired;
    logic [ADDR_W-1:0]   r_bkpt_addr;
    logic                r_bkpt_en;
    logic                r_first;
    logic                r_halted;
    logic [1:0]          r_cause;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_waddr;
    logic [DATA_W-1:0]   r_imem_wdata;

    logic                w_cmd_ready;
    logic                w_core_en;
    logic                w_stop;
    logic [1:0]          w_stop_cause;
    logic                w_is_halt;
    logic                w_bkpt_hit;
    logic                w_limit_hit;

    assign w_is_halt   = (core_instr == HALT_INSTR);
    // first suppresses the breakpoint so a resumed run executes the breakpointed PC
    assign w_bkpt_hit  = r_bkpt_en && (core_pc == r_bkpt_addr) && !r_first;
    assign w_limit_hit = (r_limit != '0) && (r_run_cnt == r_limit);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_CRST;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cmd_ready  = 1'b0;
        w_core_en    = 1'b0;
        w_stop       = 1'b0;
        w_stop_cause = 2'd0;
        case (r_state)
            S_CRST: begin
                if (r_rst_cnt == '0) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        c_op_crst: w_state_nxt = S_CRST;
                        c_op_run:  w_state_nxt = S_RUN;
                        c_op_step: w_state_nxt = S_STEP;
                        default:   w_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid && (cmd_op == c_op_stop)) begin
                    w_stop = 1'b1; w_stop_cause = 2'd0;
                end else if (w_is_halt) begin
                    w_stop = 1'b1; w_stop_cause = 2'd1;
                end else if (w_bkpt_hit) begin
                    w_stop = 1'b1; w_stop_cause = 2'd2;
                end else if (w_limit_hit) begin
                    w_stop = 1'b1; w_stop_cause = 2'd3;
                end
                w_core_en = !w_stop;
                if (w_stop) w_state_nxt = S_IDLE;
            end
            S_STEP: begin
                w_stop       = w_is_halt;
                w_stop_cause = 2'd1;
                w_core_en    = !w_is_halt;
                w_state_nxt  = S_IDLE;
            end
        endcase
        if (reset) w_core_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rst_cnt    <= c_rst_init;
            r_limit      <= '0;
            r_run_cnt    <= '0;
            r_retired    <= '0;
            r_bkpt_addr  <= '0;
            r_bkpt_en    <= 1'b0;
            r_first      <= 1'b0;
            r_halted     <= 1'b0;
            r_cause      <= 2'd0;
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= '0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                S_CRST: begin
                    if (r_rst_cnt != '0) r_rst_cnt <= r_rst_cnt - c_rcw'(1);
                    r_halted  <= 1'b0;
                    r_retired <= '0;
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            c_op_write: begin
                                r_imem_we    <= 1'b1;
                                r_imem_waddr <= cmd_addr;
                                r_imem_wdata <= cmd_data;
                            end
                            c_op_limit: r_limit <= cmd_data[CNT_W-1:0];
                            c_op_bkpt: begin
                                r_bkpt_addr <= cmd_addr;
                                r_bkpt_en   <= cmd_data[0];
                            end
                            c_op_crst:  r_rst_cnt <= c_rst_init;
                            c_op_run: begin
                                r_run_cnt <= '0;
                                r_first   <= 1'b1;
                                r_halted  <= 1'b0;
                            end
                            c_op_step:  r_halted <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                S_RUN, S_STEP: begin
                    if (w_stop) begin
                        r_halted <= 1'b1;
                        r_cause  <= w_stop_cause;
                    end
                    if (w_core_en) begin
                        if (r_retired != '1) r_retired <= r_retired + CNT_W'(1);
                        r_run_cnt <= r_run_cnt + CNT_W'(1);
                        r_first   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign core_en     = w_core_en;
    assign core_rst    = reset | (r_state == S_CRST);
    assign busy        = (r_state != S_IDLE);
    assign halted      = r_halted;
    assign halt_cause  = r_cause;
    assign retired_cnt = r_retired;
    assign imem_we     = r_imem_we;
    assign imem_waddr  = r_imem_waddr;
    assign imem_wdata  = r_imem_wdata;

endmodule

`default_nettype wire

// File: doc/ri_run_controller.md
# ri_run_controller

Run-control sequencer for the single-cycle R/I-type datapath. Sits between a host command port and the datapath: loads instruction memory, resets the core, and gates the core's clock enable for free-running execution or single-stepping. Stops on a halt instruction, a PC breakpoint, a run-length limit, or a host STOP, and reports the cause and the retired-instruction count.

## Interface
- ADDR_W, 5: instruction-memory word-address width (32 words)
- DATA_W, 32: instruction width
- CNT_W, 16: retired/limit counter width
- RST_CYCLES, 2: cycles core_rst is held per core reset (≥1)
- HALT_INSTR, 32'hFFFF_FFFF: opcode that halts the run

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  controller accepts command this cycle
- cmd_op  in  3  0 NOP, 1 WRITE_IMEM, 2 SET_LIMIT, 3 SET_BKPT, 4 RESET_CORE, 5 RUN, 6 STEP, 7 STOP
- cmd_addr  in  ADDR_W  imem/breakpoint address
- cmd_data  in  DATA_W  imem word / limit (low CNT_W bits) / bkpt enable (bit 0)
- imem_we, imem_waddr, imem_wdata  out  1/ADDR_W/DATA_W  imem write port
- core_pc  in  ADDR_W  datapath current PC (word address)
- core_instr  in  DATA_W  instruction currently fetched at core_pc
- core_en  out  1  datapath state-update enable (PC, regfile, dmem writes)
- core_rst  out  1  datapath synchronous reset
- busy  out  1  state is RUN, STEP or CRST
- halted  out  1  sticky: run ended
- halt_cause  out  2  0 host STOP, 1 halt instr, 2 breakpoint, 3 limit
- retired_cnt  out  CNT_W  instructions retired since last core reset, saturating

## Operation
- States: CRST, IDLE, RUN, STEP. Accept = cmd_valid & cmd_ready.
- cmd_ready = 1 in IDLE and RUN; 0 in CRST and STEP.
- reset: state←CRST, rst counter←RST_CYCLES-1, limit←0, bkpt disabled, halted←0, cause←0, retired_cnt←0, imem_we←0. core_rst = reset | (state==CRST).
- CRST: core_rst=1, core_en=0; counts down, then IDLE. Clears halted and retired_cnt.
- IDLE accepts: WRITE_IMEM → imem_we pulses 1 cycle, registered, with cmd_addr/cmd_data. SET_LIMIT → limit (0 = unlimited). SET_BKPT → bkpt_addr=cmd_addr, bkpt_en=cmd_data[0]. RESET_CORE → CRST. RUN → RUN, run_cnt←0, first←1, halted←0. STEP → STEP, halted←0. STOP/NOP → no effect.
- RUN, per cycle (combinational, priority order), with core_en=1 only if no stop condition:
  1. accepted STOP → cause 0
  2. core_instr==HALT_INSTR → cause 1
  3. bkpt_en & core_pc==bkpt_addr & !first → cause 2
  4. limit≠0 & run_cnt==limit → cause 3
  On a stop condition: core_en=0, halted←1, cause latched, next state IDLE. Otherwise run_cnt++, retired_cnt++ (saturating at all-ones), first←0.
- In RUN, any accepted op other than STOP is consumed and ignored.
- STEP: single cycle. core_en=1 unless core_instr==HALT_INSTR (then halted←1, cause 1). Breakpoint and limit ignored. retired_cnt++ when core_en. Next state IDLE.
- Resuming RUN at a breakpointed PC executes that instruction (first flag).

## Timing
- WRITE_IMEM: imem_we high the cycle after accept, for exactly one cycle.
- RUN accepted at edge N: core_en may assert in cycle N+1; N instructions retire in N consecutive cycles.
- Stop detection is same-cycle: the stopping instruction is not executed (core_en low); halted/busy update at the next edge.
- core_rst is high during reset and for exactly RST_CYCLES cycles after RESET_CORE accept or reset deassertion; cmd_ready returns the next cycle.
- reset asserted mid-RUN: core_en drops that cycle; state and counters restore reset values.

## Test plan
- Reset release → core_rst high 2 cycles, cmd_ready=1 afterwards, retired_cnt=0, halted=0.
- WRITE_IMEM addr 3, data 32'h0123_4567 → next cycle imem_we=1, waddr=3, wdata=32'h0123_4567; low after.
- Program with HALT_INSTR at PC 5, RUN → core_en high exactly 5 cycles, halted=1, cause=1, retired_cnt=5.
- SET_BKPT addr 2 enabled, RUN → stops at PC 2 with cause 2, retired_cnt=2; RUN again → PC 2 executes, continues to the halt.
- SET_LIMIT 3, RUN on an endless loop → 3 retirements, cause 3; STOP issued mid-run without a limit → core_en low that cycle, cause 0.
- STEP ×2 from reset → retired_cnt=2, cmd_ready low in each STEP cycle; STEP at HALT_INSTR → core_en stays 0, cause 1.
